// File: rtl/word_align_ctrl.sv
// word_align_ctrl: finds the bit offset (0-7) at which a repeating training
// word lines up in the deserialized P-path stream, re-frames the stream at
// that offset and monitors lock.
// Optional build macro: WORD_ALIGN_INVERT_EN. When defined, the inverted
// training word also matches, and a polarity_inv output records which
// polarity was found at lock. aligned_data is then inverted back to true
// polarity.
module word_align_ctrl #(
  parameter int unsigned MATCH_REQ  = 16,
  parameter int unsigned MISS_MAX   = 4,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        clk160,
  input  logic        totalCounterResetb_manual,
  input  logic [7:0]  D_OUT_P,
  input  logic        delay_ready,
  input  logic        align_enable,
  input  logic [7:0]  sync_pattern,
  output logic [7:0]  aligned_data,
  output logic        aligned_valid,
  output logic [2:0]  bit_offset,
  output logic        locked,
  output logic        align_fail,
  output logic [15:0] lock_loss_cnt
`ifdef WORD_ALIGN_INVERT_EN
  ,
  output logic        polarity_inv
`endif
);

  localparam int unsigned WORD_W = 8;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SET_W  = 4;
  localparam int unsigned LOSS_W = 16;

  localparam logic [CNT_W-1:0]  MATCH_LAST = CNT_W'(MATCH_REQ - 1);
  localparam logic [CNT_W-1:0]  MISS_LAST  = CNT_W'(MISS_MAX - 1);
  localparam logic [SET_W-1:0]  SETTLE_LD  = SET_W'(SETTLE_CYC);
  localparam logic [LOSS_W-1:0] LOSS_MAX   = {LOSS_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Only the low 7 bits of the previous word ever fall inside a window.
  logic [WORD_W-2:0]   r_prev_low;
  logic [WORD_W-1:0]   r_aligned_data;
  logic                r_aligned_valid;
  logic [OFF_W-1:0]    r_bit_offset;
  logic [OFF_W-1:0]    r_start_off;
  logic [CNT_W-1:0]    r_match_cnt;
  logic [CNT_W-1:0]    r_miss_cnt;
  logic [SET_W-1:0]    r_settle_cnt;
  logic                r_locked;
  logic                r_align_fail;
  logic [LOSS_W-1:0]   r_lock_loss_cnt;

  logic [OFF_W-1:0]    w_off_nxt;
  logic [OFF_W-1:0]    w_start_nxt;
  logic [CNT_W-1:0]    w_match_nxt;
  logic [CNT_W-1:0]    w_miss_nxt;
  logic [SET_W-1:0]    w_settle_nxt;
  logic                w_locked_nxt;
  logic                w_fail_nxt;
  logic [LOSS_W-1:0]   w_loss_nxt;
  logic [OFF_W-1:0]    w_off_inc;

  logic [2*WORD_W-2:0] w_cat;
  logic [WORD_W-1:0]   w_window;
  logic                w_match_true;
  logic                w_search_match;
  logic                w_locked_match;
  logic                w_abort;

`ifdef WORD_ALIGN_INVERT_EN
  logic                r_polarity;
  logic                w_pol_nxt;
  logic                w_match_inv;
`endif

  assign w_cat        = {r_prev_low, D_OUT_P};
  assign w_abort      = !align_enable || !delay_ready;
  assign w_off_inc    = r_bit_offset + OFF_W'(1);
  assign w_match_true = (w_window == sync_pattern);

`ifdef WORD_ALIGN_INVERT_EN
  assign w_match_inv    = (w_window == ~sync_pattern);
  assign w_search_match = w_match_true || w_match_inv;
  assign w_locked_match = r_polarity ? w_match_inv : w_match_true;
  assign polarity_inv   = r_polarity;
`else
  assign w_search_match = w_match_true;
  assign w_locked_match = w_match_true;
`endif

  assign aligned_data  = r_aligned_data;
  assign aligned_valid = r_aligned_valid;
  assign bit_offset    = r_bit_offset;
  assign locked        = r_locked;
  assign align_fail    = r_align_fail;
  assign lock_loss_cnt = r_lock_loss_cnt;

  // Select the 8-bit window starting at the current offset.
  always_comb begin
    w_window = w_cat[WORD_W-1:0];
    case (r_bit_offset)
      3'd0: w_window = w_cat[7:0];
      3'd1: w_window = w_cat[8:1];
      3'd2: w_window = w_cat[9:2];
      3'd3: w_window = w_cat[10:3];
      3'd4: w_window = w_cat[11:4];
      3'd5: w_window = w_cat[12:5];
      3'd6: w_window = w_cat[13:6];
      default: w_window = w_cat[14:7];
    endcase
  end

  // Next-state and next-value logic; abort overrides every other decision.
  always_comb begin
    w_state_nxt  = r_state;
    w_off_nxt    = r_bit_offset;
    w_start_nxt  = r_start_off;
    w_match_nxt  = r_match_cnt;
    w_miss_nxt   = r_miss_cnt;
    w_settle_nxt = r_settle_cnt;
    w_locked_nxt = r_locked;
    w_fail_nxt   = r_align_fail;
    w_loss_nxt   = r_lock_loss_cnt;
`ifdef WORD_ALIGN_INVERT_EN
    w_pol_nxt    = r_polarity;
`endif
    if (w_abort) begin
      w_state_nxt  = ST_IDLE;
      w_locked_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_match_nxt  = '0;
          w_miss_nxt   = '0;
          w_locked_nxt = 1'b0;
          w_start_nxt  = r_bit_offset;
          w_state_nxt  = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (!w_search_match) begin
            w_state_nxt = ST_SLIP;
          end else if (r_match_cnt == MATCH_LAST) begin
            w_state_nxt  = ST_LOCKED;
            w_locked_nxt = 1'b1;
            w_miss_nxt   = '0;
            w_fail_nxt   = 1'b0;
`ifdef WORD_ALIGN_INVERT_EN
            w_pol_nxt    = !w_match_true;
`endif
          end else begin
            w_match_nxt = r_match_cnt + CNT_W'(1);
          end
        end
        ST_SLIP: begin
          w_off_nxt    = w_off_inc;
          w_match_nxt  = '0;
          w_settle_nxt = SETTLE_LD;
          w_state_nxt  = ST_SETTLE;
          if (w_off_inc == r_start_off) begin
            w_fail_nxt = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == '0) begin
            w_state_nxt = ST_SEARCH;
          end else begin
            w_settle_nxt = r_settle_cnt - SET_W'(1);
          end
        end
        ST_LOCKED: begin
          if (w_locked_match) begin
            w_miss_nxt = '0;
          end else if (r_miss_cnt == MISS_LAST) begin
            w_state_nxt  = ST_SEARCH;
            w_locked_nxt = 1'b0;
            w_match_nxt  = '0;
            w_start_nxt  = r_bit_offset;
            if (r_lock_loss_cnt != LOSS_MAX) begin
              w_loss_nxt = r_lock_loss_cnt + LOSS_W'(1);
            end
          end else begin
            w_miss_nxt = r_miss_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
    if (!totalCounterResetb_manual) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control registers: offset, counters, lock/fail flags.
  always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
    if (!totalCounterResetb_manual) begin
      r_bit_offset    <= '0;
      r_start_off     <= '0;
      r_match_cnt     <= '0;
      r_miss_cnt      <= '0;
      r_settle_cnt    <= '0;
      r_locked        <= 1'b0;
      r_align_fail    <= 1'b0;
      r_lock_loss_cnt <= '0;
`ifdef WORD_ALIGN_INVERT_EN
      r_polarity      <= 1'b0;
`endif
    end else begin
      r_bit_offset    <= w_off_nxt;
      r_start_off     <= w_start_nxt;
      r_match_cnt     <= w_match_nxt;
      r_miss_cnt      <= w_miss_nxt;
      r_settle_cnt    <= w_settle_nxt;
      r_locked        <= w_locked_nxt;
      r_align_fail    <= w_fail_nxt;
      r_lock_loss_cnt <= w_loss_nxt;
`ifdef WORD_ALIGN_INVERT_EN
      r_polarity      <= w_pol_nxt;
`endif
    end
  end

  // Datapath: previous-word history and the re-framed output word.
  always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
    if (!totalCounterResetb_manual) begin
      r_prev_low      <= '0;
      r_aligned_data  <= '0;
      r_aligned_valid <= 1'b0;
    end else begin
      r_prev_low      <= D_OUT_P[WORD_W-2:0];
`ifdef WORD_ALIGN_INVERT_EN
      r_aligned_data  <= r_polarity ? ~w_window : w_window;
`else
      r_aligned_data  <= w_window;
`endif
      r_aligned_valid <= (r_state == ST_LOCKED) && !w_abort;
    end
  end

endmodule

// File: tb/tb_word_align_ctrl.sv
// Bench for word_align_ctrl: directed scenarios plus randomized pattern/phase
// trials; a scoreboard queue carries the expected re-framed word of every
// cycle and a monitor compares it whenever aligned_valid is high.
module tb_word_align_ctrl;

  logic        clk160 = 1'b0;
  logic        totalCounterResetb_manual;
  logic [7:0]  D_OUT_P;
  logic        delay_ready;
  logic        align_enable;
  logic [7:0]  sync_pattern;
  logic [7:0]  aligned_data;
  logic        aligned_valid;
  logic [2:0]  bit_offset;
  logic        locked;
  logic        align_fail;
  logic [15:0] lock_loss_cnt;
`ifdef WORD_ALIGN_INVERT_EN
  logic        polarity_inv;
`endif

  int          n_checks = 0;
  int          n_err    = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  m_prev;
  int          m_off;
  logic        m_inv;
  logic [7:0]  mon_exp;

  always #5 clk160 = ~clk160;

  word_align_ctrl dut (
    .clk160                    (clk160),
    .totalCounterResetb_manual (totalCounterResetb_manual),
    .D_OUT_P                   (D_OUT_P),
    .delay_ready               (delay_ready),
    .align_enable              (align_enable),
    .sync_pattern              (sync_pattern),
    .aligned_data              (aligned_data),
    .aligned_valid             (aligned_valid),
    .bit_offset                (bit_offset),
    .locked                    (locked),
    .align_fail                (align_fail),
    .lock_loss_cnt             (lock_loss_cnt)
`ifdef WORD_ALIGN_INVERT_EN
    ,
    .polarity_inv              (polarity_inv)
`endif
  );

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] d;
    d = {v, v} << (k % 8);
    return d[15:8];
  endfunction

  // Bits of the 16-bit {previous, current} concatenation starting at off.
  function automatic logic [7:0] ref_window(input logic [7:0] p, input logic [7:0] c, input int off);
    logic [15:0] d;
    d = {p, c} >> off;
    return d[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One word clock: drive a word, record its expected framed output, step.
  task automatic tick(input logic [7:0] w);
    logic [7:0] e;
    @(negedge clk160);
    D_OUT_P = w;
    e = ref_window(m_prev, w, m_off);
    if (m_inv) e = ~e;
    exp_q.push_back(e);
    @(posedge clk160);
    #2;
    m_prev = w;
  endtask

  task automatic wait_lock(input logic [7:0] w, input int budget, output int n);
    n = 0;
    do begin
      tick(w);
      n++;
    end while (!locked && n < budget);
  endtask

  // Scoreboard monitor.
  initial begin
    forever begin
      @(posedge clk160);
      #1;
      if (exp_q.size() == 0) begin
        if (aligned_valid === 1'b1) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_empty: aligned_valid=1 with no expected word at %0t", $time);
        end
      end else begin
        mon_exp = exp_q.pop_front();
        if (aligned_valid === 1'b1) check("sb_data", 32'(aligned_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int         n;
    logic [7:0] w;
    logic [7:0] p;
    logic [15:0] loss0;
    int          k;
    bit          ok;

    totalCounterResetb_manual = 1'b0;
    align_enable = 1'b0;
    delay_ready  = 1'b0;
    D_OUT_P      = 8'h00;
    sync_pattern = 8'hAC;
    m_prev = 8'h00;
    m_off  = 0;
    m_inv  = 1'b0;

    #3;
    check("rst_data", 32'(aligned_data), 32'h0);
    check("rst_valid", 32'(aligned_valid), 32'h0);
    check("rst_offset", 32'(bit_offset), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_fail", 32'(align_fail), 32'h0);
    check("rst_loss", 32'(lock_loss_cnt), 32'h0);
`ifdef WORD_ALIGN_INVERT_EN
    check("rst_pol", 32'(polarity_inv), 32'h0);
`endif
    #4;
    totalCounterResetb_manual = 1'b1;

    // Aligned stream at offset 0: 1 IDLE cycle + 16 matches.
    align_enable = 1'b1;
    delay_ready  = 1'b1;
    wait_lock(8'hAC, 100, n);
    check("t2_lock_cycles", 32'(n), 32'd17);
    check("t2_offset", 32'(bit_offset), 32'd0);
    check("t2_fail", 32'(align_fail), 32'd0);
    tick(8'hAC);
    check("t2_valid", 32'(aligned_valid), 32'd1);
    check("t2_data", 32'(aligned_data), 32'hAC);

    // Three misses are tolerated, the fourth drops lock.
    repeat (3) tick(8'h00);
    repeat (2) tick(8'hAC);
    check("t3_hold_locked", 32'(locked), 32'd1);
    check("t3_hold_loss", 32'(lock_loss_cnt), 32'd0);
    repeat (3) tick(8'h00);
    check("t3_three_locked", 32'(locked), 32'd1);
    tick(8'h00);
    check("t3_drop_locked", 32'(locked), 32'd0);
    check("t3_drop_loss", 32'(lock_loss_cnt), 32'd1);
    wait_lock(8'hAC, 100, n);
    check("t3_relock_cycles", 32'(n), 32'd16);
    check("t3_relock_offset", 32'(bit_offset), 32'd0);

    // Stream shifted by 3 bits: sweep to offset 3.
    align_enable = 1'b0;
    tick(8'hAC);
    check("t1_idle_locked", 32'(locked), 32'd0);
    check("t1_idle_valid", 32'(aligned_valid), 32'd0);
    align_enable = 1'b1;
    m_off = 3;
    w = rotl8(8'hAC, 3);
    wait_lock(w, 300, n);
    check("t1_locked", 32'(locked), 32'd1);
    check("t1_offset", 32'(bit_offset), 32'd3);
    check("t1_fail", 32'(align_fail), 32'd0);
    tick(w);
    check("t1_valid", 32'(aligned_valid), 32'd1);
    check("t1_data", 32'(aligned_data), 32'hAC);

    // Random data: a full sweep sets align_fail back at the start offset.
    align_enable = 1'b0;
    tick(w);
    align_enable = 1'b1;
    n = 0;
    do begin
      tick(8'($urandom));
      n++;
    end while (!align_fail && n < 600);
    check("t4_fail_set", 32'(align_fail), 32'd1);
    check("t4_fail_offset", 32'(bit_offset), 32'd3);
    check("t4_fail_locked", 32'(locked), 32'd0);
    m_off = 5;
    w = rotl8(8'hAC, 5);
    wait_lock(w, 300, n);
    check("t4_locked", 32'(locked), 32'd1);
    check("t4_offset", 32'(bit_offset), 32'd5);
    check("t4_fail_clr", 32'(align_fail), 32'd0);

    // One-cycle delay_ready drop: IDLE, offset kept, relock without slips.
    delay_ready = 1'b0;
    tick(w);
    check("t5_locked", 32'(locked), 32'd0);
    check("t5_valid", 32'(aligned_valid), 32'd0);
    check("t5_offset", 32'(bit_offset), 32'd5);
    delay_ready = 1'b1;
    wait_lock(w, 100, n);
    check("t5_relock_cycles", 32'(n), 32'd17);
    check("t5_relock_offset", 32'(bit_offset), 32'd5);

    // Reset asserted mid-SETTLE clears everything asynchronously.
    align_enable = 1'b0;
    tick(w);
    align_enable = 1'b1;
    repeat (3) tick(8'h00);
    check("t6_pre_offset", 32'(bit_offset), 32'd6);
    check("t6_pre_loss", 32'(lock_loss_cnt), 32'd1);
    #1;
    totalCounterResetb_manual = 1'b0;
    #1;
    check("t6_data", 32'(aligned_data), 32'h0);
    check("t6_valid", 32'(aligned_valid), 32'h0);
    check("t6_offset", 32'(bit_offset), 32'h0);
    check("t6_locked", 32'(locked), 32'h0);
    check("t6_fail", 32'(align_fail), 32'h0);
    check("t6_loss", 32'(lock_loss_cnt), 32'h0);
    repeat (2) tick(8'h00);
    check("t6_held_offset", 32'(bit_offset), 32'h0);
    totalCounterResetb_manual = 1'b1;
    m_prev = 8'h00;

`ifdef WORD_ALIGN_INVERT_EN
    // Inverted training stream locks with polarity_inv and true-polarity data.
    m_off = 0;
    m_inv = 1'b1;
    wait_lock(~8'hAC, 100, n);
    check("inv_lock_cycles", 32'(n), 32'd17);
    check("inv_pol", 32'(polarity_inv), 32'd1);
    tick(~8'hAC);
    check("inv_valid", 32'(aligned_valid), 32'd1);
    check("inv_data", 32'(aligned_data), 32'hAC);
    tick(8'hAC);
    tick(8'hAC);
    check("inv_true_is_miss", 32'(locked), 32'd1);
`endif

    // Randomized trials: random pattern and phase, sparse bad words.
    for (int t = 0; t < 6; t++) begin
      do begin
        p = 8'($urandom);
        ok = 1'b1;
        for (int j = 1; j < 8; j++) if (rotl8(p, j) == p) ok = 1'b0;
        for (int j = 0; j < 8; j++) if (rotl8(p, j) == ~p) ok = 1'b0;
      end while (!ok);
      k = int'($urandom_range(0, 7));
      align_enable = 1'b0;
      tick(8'h00);
      sync_pattern = p;
      m_off = k;
      m_inv = 1'b0;
      w = rotl8(p, k);
      align_enable = 1'b1;
      wait_lock(w, 300, n);
      check("rnd_locked", 32'(locked), 32'd1);
      check("rnd_offset", 32'(bit_offset), 32'(k));
      check("rnd_fail", 32'(align_fail), 32'd0);
      loss0 = lock_loss_cnt;
      for (int c = 0; c < 8; c++) begin
        tick(($urandom_range(0, 3) == 0) ? 8'($urandom) : w);
        tick(w);
        tick(w);
      end
      check("rnd_keep_locked", 32'(locked), 32'd1);
      check("rnd_keep_loss", 32'(lock_loss_cnt), 32'(loss0));
    end

    tick(w);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/word_align_ctrl.md
Name: word_align_ctrl

Overview:
Downstream of the per-lane delay controller. Takes the 8-bit deserialized P-path word stream once the delay controller reports delay_ready, and finds the bit offset (0-7) at which a repeating training pattern lines up. It then outputs re-framed words and monitors lock, counting lock losses and failed searches for slow-control readout.

Parameters:
MATCH_REQ, 16, consecutive pattern matches required to declare lock (1-255)
MISS_MAX, 4, consecutive mismatches in LOCKED that drop lock (1-255)
SETTLE_CYC, 2, idle cycles after each offset change before comparing (0-15)

Ports:
clk160  in  1  word clock
totalCounterResetb_manual  in  1  asynchronous active-low reset
D_OUT_P  in  8  deserialized word, bit 7 first in time
delay_ready  in  1  delay controller settled; alignment only runs while high
align_enable  in  1  level; high = search/track, low = return to IDLE
sync_pattern  in  8  training word
aligned_data  out  8  re-framed word
aligned_valid  out  1  aligned_data valid (LOCKED only)
bit_offset  out  3  current window offset
locked  out  1  lock status
align_fail  out  1  sticky: full 8-offset sweep without lock
lock_loss_cnt  out  16  saturating count of LOCKED->SEARCH transitions

Behaviour:
- Reset: all outputs 0, state IDLE, prev_word 0, match and miss counters 0.
- prev_word <= D_OUT_P every cycle. cat = {prev_word, D_OUT_P}, 16 bits. window = cat[bit_offset+7 : bit_offset]; offset 0 = current word.
- aligned_data <= window every cycle: 1-cycle latency, valid in all states. aligned_valid <= (state==LOCKED), registered alongside.
- match = (window == sync_pattern), combinational on the current cycle.
- States:
  - IDLE: match_cnt=0, miss_cnt=0, locked=0. Go to SEARCH when align_enable && delay_ready.
  - SEARCH: on match, match_cnt+1; on mismatch, go to SLIP. When match_cnt reaches MATCH_REQ-1 and the current cycle matches, go to LOCKED with locked=1 and miss_cnt=0.
  - SLIP: bit_offset <= bit_offset+1, wrapping 7->0. match_cnt=0. Load settle counter with SETTLE_CYC, then go to SETTLE. If the wrap returns bit_offset to the offset the sweep started at, set align_fail=1 and keep sweeping.
  - SETTLE: decrement the settle counter; at 0, go to SEARCH.
  - LOCKED: on match, miss_cnt=0; on mismatch, miss_cnt+1. When miss_cnt reaches MISS_MAX-1 and the current cycle mismatches: locked=0, lock_loss_cnt+1 (saturates at 16'hFFFF), go to SEARCH at the same offset with match_cnt=0.
- Sweep start offset: latched on every entry into SEARCH from IDLE or LOCKED.
- align_fail: cleared only by reset or by a successful lock.
- Any state, align_enable=0 or delay_ready=0: next cycle go to IDLE. locked and aligned_valid drop on that edge; bit_offset is retained.
- Simultaneous: the abort condition has priority over match/lock decisions in the same cycle.
- Reset mid-operation: immediate asynchronous return to reset values, including lock_loss_cnt.
- Counter widths: match_cnt and miss_cnt are 8 bits; compares are against parameter-1.

Optional Feature:
Macro WORD_ALIGN_INVERT_EN.
- Defined:
  - match also accepts window == ~sync_pattern.
  - A registered output polarity_inv (1 bit, reset 0) is latched on lock: 1 if the inverted pattern matched.
  - While polarity_inv=1, aligned_data is ~window.
  - In LOCKED, only the latched polarity counts as a match.
- Not defined: no polarity_inv port; only the true pattern matches.

Test Plan:
1. Stream of sync_pattern=8'hAC shifted by 3 bits, delay_ready=1, align_enable=1 -> bit_offset settles at 3. locked=1 after the 16th consecutive match. aligned_data==8'hAC with aligned_valid=1 thereafter.
2. Aligned stream at offset 0 -> lock without any SLIP: locked=1 exactly 16 matching cycles after entering SEARCH, plus the 1 IDLE cycle.
3. Locked, then inject 3 bad words followed by good words -> locked stays 1, lock_loss_cnt=0. Then inject 4 bad words -> locked=0 and lock_loss_cnt=1 on the 4th bad word.
4. Random data with no pattern -> align_fail=1 after the offset wraps back to its start. Then switch to the pattern -> lock achieved and align_fail clears to 0.
5. Locked, drop delay_ready for 1 cycle -> next cycle IDLE with locked=0 and bit_offset unchanged. On re-assertion, relock at the same offset without slipping.
6. Assert totalCounterResetb_manual low mid-SETTLE -> all outputs 0 asynchronously, including lock_loss_cnt. With WORD_ALIGN_INVERT_EN defined and stream ~8'hAC, lock with polarity_inv=1 and aligned_data=8'hAC.
